// File: rtl/vslide_stream.sv
// Streaming byte slide (up/down, optional scalar insert) with a one-beat carry or hold register.
// Latency: UP 1 cycle from accept; DOWN emits beat k when beat k+1 is accepted, and the last beat during FLUSH.
// Backpressure: single output register; in_ready = ~FLUSH & (~out_valid | out_ready).
module vslide_stream #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int OFF_WIDTH    = 12,
  parameter int SCALAR_WIDTH = 64,
  parameter int SHIFT_WIDTH  = $clog2(DATA_WIDTH/8) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_vec,
  input  logic [DATA_WIDTH/8-1:0]   in_be,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [OFF_WIDTH-1:0]      in_off,
  input  logic                      in_start,
  input  logic                      in_end,
  input  logic                      in_opSel,
  input  logic                      in_insert,
  input  logic [SHIFT_WIDTH-1:0]    in_shift,
  input  logic [SCALAR_WIDTH-1:0]   in_scalar,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_vec,
  output logic [DATA_WIDTH/8-1:0]   out_be,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [OFF_WIDTH-1:0]      out_off
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW    = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] DW_B = BW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, UP, DOWN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [SHIFT_WIDTH-1:0]  shift_r;
  logic                    ins_r;
  logic [SCALAR_WIDTH-1:0] scalar_r;
  logic [DATA_WIDTH-1:0]   carry_r, held_vec;
  logic [BYTES-1:0]        held_be;
  logic [ADDR_WIDTH-1:0]   held_addr;

  logic                    load_ok, accept, is_start, ld_out, hold, carry_we;
  logic [SHIFT_WIDTH-1:0]  cur_shift;
  logic                    cur_ins;
  logic [DATA_WIDTH-1:0]   cur_scalar, carry_in, up_vec, dn_vec, fl_vec, nxt_vec;
  logic [BYTES-1:0]        up_be, fl_be, nxt_be;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic [OFF_WIDTH-1:0]    nxt_off;
  logic [BW-1:0]           lsh, rsh;

  always_comb begin
    load_ok    = ~out_valid | out_ready;
    in_ready   = rst_n & (state != FLUSH) & load_ok;
    accept     = in_valid & in_ready;
    is_start   = (state == IDLE) & in_start;
    // Start-beat controls are used directly; later beats use the sampled copies.
    cur_shift  = is_start ? in_shift : shift_r;
    cur_ins    = is_start ? in_insert : ins_r;
    cur_scalar = is_start ? DATA_WIDTH'(in_scalar) : DATA_WIDTH'(scalar_r);
    lsh        = BW'({cur_shift, 3'b000});
    rsh        = DW_B - lsh;

    carry_in = carry_r;
    if (is_start)
      carry_in = cur_ins ? (cur_scalar & ~({DATA_WIDTH{1'b1}} << lsh)) : '0;
    up_vec = (in_vec << lsh) | carry_in;
    up_be  = (is_start & ~cur_ins) ? (in_be & ({BYTES{1'b1}} << cur_shift)) : in_be;
    dn_vec = (held_vec >> lsh) | (in_vec << rsh);
    fl_vec = (held_vec >> lsh) | (cur_ins ? (cur_scalar << rsh) : '0);
    fl_be  = cur_ins ? held_be : (held_be & ({BYTES{1'b1}} >> cur_shift));

    state_nxt = state;
    ld_out    = 1'b0;
    hold      = 1'b0;
    carry_we  = 1'b0;
    nxt_vec   = up_vec;
    nxt_be    = up_be;
    nxt_addr  = in_addr;
    nxt_off   = in_off;
    case (state)
      IDLE: begin
        if (accept && in_start) begin
          if (in_opSel) begin
            hold      = 1'b1;
            state_nxt = in_end ? FLUSH : DOWN;
          end else begin
            ld_out    = 1'b1;
            carry_we  = 1'b1;
            state_nxt = in_end ? IDLE : UP;
          end
        end
      end
      UP: begin
        if (accept) begin
          ld_out   = 1'b1;
          carry_we = 1'b1;
          if (in_end) state_nxt = IDLE;
        end
      end
      DOWN: begin
        if (accept) begin
          ld_out   = 1'b1;
          hold     = 1'b1;
          nxt_vec  = dn_vec;
          nxt_be   = held_be;
          nxt_addr = held_addr;
          nxt_off  = '0;
          if (in_end) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (load_ok) begin
          ld_out    = 1'b1;
          nxt_vec   = fl_vec;
          nxt_be    = fl_be;
          nxt_addr  = held_addr;
          nxt_off   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_r   <= '0;
      ins_r     <= 1'b0;
      scalar_r  <= '0;
      carry_r   <= '0;
      held_vec  <= '0;
      held_be   <= '0;
      held_addr <= '0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_be    <= '0;
      out_addr  <= '0;
      out_off   <= '0;
    end else begin
      state <= state_nxt;
      if (accept && is_start) begin
        shift_r  <= in_shift;
        ins_r    <= in_insert;
        scalar_r <= in_scalar;
      end
      if (carry_we) carry_r <= in_vec >> rsh;
      if (hold) begin
        held_vec  <= in_vec;
        held_be   <= in_be;
        held_addr <= in_addr;
      end
      if (ld_out) begin
        out_valid <= 1'b1;
        out_vec   <= nxt_vec;
        out_be    <= nxt_be;
        out_addr  <= nxt_addr;
        out_off   <= nxt_off;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // The scalar has to supply every byte that an insert shifts in.
  insert_fits_scalar: assert property (@(posedge clk) disable iff (!rst_n)
    (accept && is_start && in_insert) |-> (int'(in_shift) * 8 <= SCALAR_WIDTH));
endmodule

// File: tb/tb_vslide_stream.sv
// Scoreboard bench for vslide_stream: byte-array reference model, random streams, directed corner cases.
module tb_vslide_stream;
  localparam int DW = 64, B = 8, AW = 32, OW = 12, SW = 64, SHW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, in_start, in_end, in_opSel, in_insert;
  logic [DW-1:0] in_vec, out_vec;
  logic [B-1:0]  in_be, out_be;
  logic [AW-1:0] in_addr, out_addr;
  logic [OW-1:0] in_off, out_off;
  logic [SHW-1:0] in_shift;
  logic [SW-1:0] in_scalar;
  logic          out_valid, out_ready;

  vslide_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OFF_WIDTH(OW), .SCALAR_WIDTH(SW), .SHIFT_WIDTH(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_be(in_be), .in_addr(in_addr), .in_off(in_off), .in_start(in_start), .in_end(in_end),
    .in_opSel(in_opSel), .in_insert(in_insert), .in_shift(in_shift), .in_scalar(in_scalar),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_be(out_be),
    .out_addr(out_addr), .out_off(out_off));

  typedef struct packed {
    logic [DW-1:0] vec;
    logic [B-1:0]  be;
    logic [AW-1:0] addr;
    logic [OW-1:0] off;
  } beat_t;

  beat_t         expq[$];
  logic [DW-1:0] vq[$];
  logic [B-1:0]  bq[$];
  logic [AW-1:0] aq[$];
  logic [OW-1:0] oq[$];
  int checks = 0, errors = 0, nout = 0;
  int unsigned rdy_pct = 100;
  bit stall = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, req);
    end
  endtask

  // Output monitor: randomizes out_ready, pops the scoreboard on every handshake.
  initial begin
    beat_t got, exp, held;
    bit pstall;
    pstall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = {out_vec, out_be, out_addr, out_off};
      if (pstall) begin
        checks++;
        if (!out_valid || got !== held) begin
          errors++;
          $display("FAIL hold_stable got valid=%0b %h required valid=1 %h", out_valid, got, held);
        end
      end
      out_ready = (stall || !rst_n) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
      pstall = rst_n && out_valid && !out_ready;
      held = got;
      if (out_valid && out_ready) begin
        nout++;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got vec=%h be=%h addr=%h", got.vec, got.be, got.addr);
        end else begin
          exp = expq.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL beat got vec=%h be=%h addr=%h off=%h required vec=%h be=%h addr=%h off=%h",
                     got.vec, got.be, got.addr, got.off, exp.vec, exp.be, exp.addr, exp.off);
          end
        end
      end
    end
  end

  // Reference: view the vector as one flat byte string and slide it by s bytes.
  task automatic push_model(input bit down, input bit ins, input int s, input logic [63:0] scalar);
    int n;
    n = vq.size();
    for (int k = 0; k < n; k++) begin
      beat_t e;
      logic [DW-1:0] src;
      logic [B-1:0] cbe;
      e = '0;
      cbe = bq[k];
      for (int b = 0; b < B; b++) begin
        int g;
        logic [7:0] byt;
        byt = 8'h00;
        if (!down) begin
          g = k * B + b - s;
          if (g >= 0) begin
            src = vq[g / B];
            byt = src[(g % B) * 8 +: 8];
          end else if (ins) begin
            byt = scalar[(k * B + b) * 8 +: 8];
          end
          e.be[b] = (k == 0 && !ins) ? (cbe[b] && b >= s) : cbe[b];
        end else begin
          g = k * B + b + s;
          if (g < n * B) begin
            src = vq[g / B];
            byt = src[(g % B) * 8 +: 8];
          end else if (ins) begin
            byt = scalar[(g - n * B) * 8 +: 8];
          end
          e.be[b] = (k == n - 1 && !ins) ? (cbe[b] && b < B - s) : cbe[b];
        end
        e.vec[b * 8 +: 8] = byt;
      end
      e.addr = aq[k];
      e.off = down ? '0 : oq[k];
      expq.push_back(e);
    end
  endtask

  // Called and returns at negedge+1; in_ready is sampled just before the posedge.
  task automatic send_beat(input int k, input int n, input bit down, input bit ins, input int s,
                           input logic [63:0] scalar);
    bit acc;
    int t;
    t = 0;
    in_valid = 1'b1;
    in_vec = vq[k]; in_be = bq[k]; in_addr = aq[k]; in_off = oq[k];
    in_start = (k == 0); in_end = (k == n - 1);
    in_opSel = down; in_insert = ins; in_shift = SHW'(s); in_scalar = scalar;
    forever begin
      #3;
      acc = in_ready;
      @(negedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 500) begin
        chk("accept_timeout", 64'(acc), 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drive_vector(input bit down, input bit ins, input int s, input logic [63:0] scalar,
                              input bit gaps);
    int n;
    n = vq.size();
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #1;
      end
      send_beat(k, n, down, ins, s, scalar);
    end
  endtask

  task automatic rand_vector(input int n);
    vq.delete(); bq.delete(); aq.delete(); oq.delete();
    for (int k = 0; k < n; k++) begin
      vq.push_back({$urandom, $urandom});
      bq.push_back(B'($urandom));
      aq.push_back($urandom);
      oq.push_back(OW'($urandom));
    end
  endtask

  task automatic two_beats();
    vq = '{64'h0807060504030201, 64'h100F0E0D0C0B0A09};
    bq = '{8'hFF, 8'hFF};
    aq = '{32'h100, 32'h108};
    oq = '{12'h005, 12'h006};
  endtask

  task automatic one_beat();
    vq = '{64'h1111111122222222};
    bq = '{8'hFF};
    aq = '{32'h200};
    oq = '{12'h007};
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || out_valid) && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("drain_left", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    logic [63:0] sc;
    rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; in_be = '0; in_addr = '0; in_off = '0;
    in_start = 1'b0; in_end = 1'b0; in_opSel = 1'b0; in_insert = 1'b0; in_shift = '0;
    in_scalar = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_vec", out_vec, 64'd0);
    chk("reset_out_be", 64'(out_be), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b1;

    two_beats();
    expq.push_back({64'h0706050403020100, 8'hFE, 32'h100, 12'h005});
    expq.push_back({64'h0F0E0D0C0B0A0908, 8'hFF, 32'h108, 12'h006});
    drive_vector(1'b0, 1'b0, 1, 64'd0, 1'b0);
    drain();

    two_beats();
    expq.push_back({64'h0A09080706050403, 8'hFF, 32'h100, 12'h000});
    expq.push_back({64'h0000100F0E0D0C0B, 8'h3F, 32'h108, 12'h000});
    drive_vector(1'b1, 1'b0, 2, 64'd0, 1'b0);
    drain();

    one_beat();
    expq.push_back({64'h22222222DEADBEEF, 8'hFF, 32'h200, 12'h007});
    drive_vector(1'b0, 1'b1, 4, 64'hDEADBEEF, 1'b0);
    drain();

    one_beat();
    expq.push_back({64'hCAFEF00D11111111, 8'hFF, 32'h200, 12'h000});
    drive_vector(1'b1, 1'b1, 4, 64'hCAFEF00D, 1'b0);
    drain();

    // Random streams covering s = 0..BYTES, both directions, with and without insert.
    rdy_pct = 70;
    for (int v = 0; v < 40; v++) begin
      bit down, ins;
      int s;
      down = 1'($urandom);
      ins = 1'($urandom);
      s = $urandom_range(0, B);
      sc = {$urandom, $urandom};
      rand_vector($urandom_range(1, 6));
      push_model(down, ins, s, sc);
      drive_vector(down, ins, s, sc, 1'b1);
    end
    drain();

    // Five-cycle output stall in the middle of an 8-beat DOWN stream.
    rdy_pct = 100;
    sc = {$urandom, $urandom};
    rand_vector(8);
    push_model(1'b1, 1'b1, 3, sc);
    base = nout;
    fork
      drive_vector(1'b1, 1'b1, 3, sc, 1'b0);
      begin
        t = 0;
        while (nout < base + 2 && t < 500) begin
          @(negedge clk);
          t++;
        end
        #1 stall = 1'b1;
        repeat (5) begin
          @(negedge clk);
          #4;
          if (out_valid) chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        stall = 1'b0;
      end
    join
    drain();
    chk("stall_out_count", 64'(nout - base), 64'd8);

    // Reset one cycle after a DOWN start: the held beat must vanish.
    rand_vector(2);
    send_beat(0, 2, 1'b1, 1'b0, 5, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("postreset_out_valid", 64'(out_valid), 64'd0);
    two_beats();
    expq.push_back({64'h0706050403020100, 8'hFE, 32'h100, 12'h005});
    expq.push_back({64'h0F0E0D0C0B0A0908, 8'hFF, 32'h108, 12'h006});
    drive_vector(1'b0, 1'b0, 1, 64'd0, 1'b0);
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
